// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one 8n1 UART transmitter between N byte streams.
// Optional lock timeout in HOLD is enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1_000_000
) (
    input  logic           reset,
    input  logic           clk_i,
    input  logic [N-1:0]   req_valid_i,
    input  logic [8*N-1:0] req_data_i,
    input  logic [N-1:0]   req_last_i,
    output logic [N-1:0]   req_ack_o,
    output logic [N-1:0]   grant_o,
    output logic           busy_o,
    output logic [7:0]     uart_tx_data_o,
    output logic           uart_tx_ready_o,
    input  logic           uart_tx_idle_i,
    output logic           timeout_o
);
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT, HOLD} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] gidx_q, gidx_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [7:0]       data_q, data_d;
    logic             last_q, last_d;
    logic             ready_q, ready_d;
    logic             timeout_q, timeout_d;
    logic [N-1:0]     ack;

    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic [N-1:0]     pick_hot;
    logic [IDX_W-1:0] cap_idx;
    logic [7:0]       cap_data;
    logic             cap_last;
    logic             own_vld;
    int               idx;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    logic timeout_unused;
    assign timeout_unused = ^TIMEOUT;
`endif

    // Priority runs from ptr+1 upward with wrap; later loop passes win, so walk the distance down to 1.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx      = 0;
        for (int i = N; i >= 1; i--) begin
            idx = int'(ptr_q) + i;
            if (idx >= N) idx = idx - N;
            for (int k = 0; k < N; k++) begin
                if (k == idx && req_valid_i[k]) begin
                    pick_vld = 1'b1;
                    pick_idx = IDX_W'(k);
                end
            end
        end
    end

    always_comb begin
        cap_idx  = (state_q == HOLD) ? gidx_q : pick_idx;
        cap_data = '0;
        cap_last = 1'b0;
        own_vld  = 1'b0;
        pick_hot = '0;
        for (int k = 0; k < N; k++) begin
            if (IDX_W'(k) == cap_idx) begin
                cap_data = req_data_i[8*k +: 8];
                cap_last = req_last_i[k];
            end
            if (IDX_W'(k) == gidx_q) own_vld = req_valid_i[k];
            pick_hot[k] = (IDX_W'(k) == pick_idx);
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gidx_d    = gidx_q;
        grant_d   = grant_q;
        data_d    = data_q;
        last_d    = last_q;
        ready_d   = ready_q;
        timeout_d = 1'b0;
        ack       = '0;
`ifdef UART_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (pick_vld && uart_tx_idle_i) begin
                    gidx_d  = pick_idx;
                    grant_d = pick_hot;
                    ack     = pick_hot;
                    data_d  = cap_data;
                    last_d  = cap_last;
                    ready_d = 1'b1;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                if (!uart_tx_idle_i) begin
                    ready_d = 1'b0;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (uart_tx_idle_i) begin
                    if (last_q) begin
                        ptr_d   = gidx_q;
                        grant_d = '0;
                        state_d = IDLE;
                    end else begin
                        state_d = HOLD;
`ifdef UART_ARB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            HOLD: begin
                // Only the owner is looked at; everyone else waits for the message to end.
                if (own_vld) begin
                    ack     = grant_q;
                    data_d  = cap_data;
                    last_d  = cap_last;
                    ready_d = 1'b1;
                    state_d = LOAD;
                end
`ifdef UART_ARB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    timeout_d = 1'b1;
                    ptr_d     = gidx_q;
                    grant_d   = '0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            ptr_q     <= IDX_W'(N - 1);
            gidx_q    <= '0;
            grant_q   <= '0;
            data_q    <= '0;
            last_q    <= 1'b0;
            ready_q   <= 1'b0;
            timeout_q <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gidx_q    <= gidx_d;
            grant_q   <= grant_d;
            data_q    <= data_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
            timeout_q <= timeout_d;
`ifdef UART_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Ack is the capture strobe of the current cycle, so it must be masked while reset is held.
    assign req_ack_o       = ack & {N{reset}};
    assign grant_o         = grant_q;
    assign busy_o          = (state_q != IDLE);
    assign uart_tx_data_o  = data_q;
    assign uart_tx_ready_o = ready_q;
    assign timeout_o       = timeout_q;

endmodule
